// File: rtl/frame_reader.sv
// frame_reader: read-only client on one memory arbiter port. A start pulse
// fetches FRAME_WORDS consecutive words beginning at base_address, keeps no
// more than PREFETCH_DEPTH words requested-but-unread, and streams them in
// address order over a valid/ready pixel interface.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   start, base_address            frame start (sampled in IDLE) and first address
//   busy, done                     frame in progress / one-cycle completion pulse
//   mem_address, mem_data_in_ready registered read request to the arbiter
//   mem_wr, mem_data_out           write side, tied off
//   mem_fifo_full                  arbiter back-pressure on requests
//   mem_data_in, mem_data_ready    read-return data and strobe
//   pixel_data, pixel_valid        head of the prefetch buffer
//   pixel_ready                    downstream accept
//   overflow                       sticky: a return arrived while the buffer was full
module frame_reader #(
   parameter int unsigned ADDRESS_WIDTH  = 25,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned FRAME_WORDS    = 2048,
   parameter int unsigned PREFETCH_DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_address,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic                     mem_wr,
   output logic [DATA_WIDTH-1:0]    mem_data_out,
   output logic                     mem_data_in_ready,
   input  logic                     mem_fifo_full,
   input  logic [DATA_WIDTH-1:0]    mem_data_in,
   input  logic                     mem_data_ready,
   output logic [DATA_WIDTH-1:0]    pixel_data,
   output logic                     pixel_valid,
   input  logic                     pixel_ready,
   output logic                     overflow
);

   localparam int unsigned CW = $clog2(FRAME_WORDS + 1);
   localparam int unsigned IW = $clog2(PREFETCH_DEPTH + 1);
   localparam int unsigned PW = $clog2(PREFETCH_DEPTH);

   localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_WORDS);
   localparam logic [IW-1:0] DEPTH_CNT = IW'(PREFETCH_DEPTH);
   localparam logic [IW:0]   DEPTH_SUM = (IW + 1)'(PREFETCH_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] base_q, base_d;
   logic [CW-1:0]            issued_q, issued_d;
   logic [CW-1:0]            delivered_q, delivered_d;
   logic [IW-1:0]            inflight_q, inflight_d;
   logic [IW-1:0]            fill_q, fill_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic                     req_q, req_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0]    buf_q [PREFETCH_DEPTH];

   logic active, accept, ret, wr_en, xfer;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      issued_d    = issued_q;
      delivered_d = delivered_q;
      inflight_d  = inflight_q;
      fill_d      = fill_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      req_d       = req_q;
      addr_d      = addr_q;
      overflow_d  = overflow_q;

      active = (state_q == S_READ) || (state_q == S_DRAIN);
      accept = req_q && !mem_fifo_full;
      ret    = active && mem_data_ready;
      wr_en  = ret && (fill_q != DEPTH_CNT);
      xfer   = (fill_q != '0) && pixel_ready;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_READ;
               base_d      = base_address;
               issued_d    = '0;
               delivered_d = '0;
               inflight_d  = '0;
               fill_d      = '0;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
            end
         end
         S_READ: begin
            if (issued_q == FRAME_CNT) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (inflight_q == '0 && fill_q == '0 && delivered_q == FRAME_CNT) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (active) begin
         issued_d    = issued_q + CW'(accept);
         inflight_d  = inflight_q + IW'(accept) - IW'(ret && (inflight_q != '0));
         fill_d      = fill_q + IW'(wr_en) - IW'(xfer);
         wr_ptr_d    = wr_ptr_q + PW'(wr_en);
         rd_ptr_d    = rd_ptr_q + PW'(xfer);
         delivered_d = delivered_q + CW'(xfer);
         if (ret && !wr_en) overflow_d = 1'b1;
      end

      // Credit is judged on the post-edge counters so that a request accepted
      // this cycle is already counted when deciding whether to present the next.
      if (req_q && !accept) begin
         req_d  = 1'b1;
         addr_d = addr_q;
      end else if (state_q == S_READ && issued_d < FRAME_CNT &&
                   ({1'b0, inflight_d} + {1'b0, fill_d}) < DEPTH_SUM) begin
         req_d  = 1'b1;
         addr_d = base_q + ADDRESS_WIDTH'(issued_d);
      end else begin
         req_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         issued_q    <= '0;
         delivered_q <= '0;
         inflight_q  <= '0;
         fill_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         req_q       <= 1'b0;
         addr_q      <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         issued_q    <= issued_d;
         delivered_q <= delivered_d;
         inflight_q  <= inflight_d;
         fill_q      <= fill_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage is cleared on reset so the head word reads zero out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < PREFETCH_DEPTH; i++) buf_q[i] <= '0;
      end else if (wr_en) begin
         buf_q[wr_ptr_q] <= mem_data_in;
      end
   end

   assign busy              = (state_q != S_IDLE);
   assign done              = (state_q == S_DONE);
   assign mem_address       = addr_q;
   assign mem_data_in_ready = req_q;
   assign mem_wr            = 1'b0;
   assign mem_data_out      = '0;
   assign pixel_data        = buf_q[rd_ptr_q];
   assign pixel_valid       = (fill_q != '0);
   assign overflow          = overflow_q;

endmodule

// File: tb/tb_frame_reader.sv
module tb_frame_reader;

   localparam int unsigned AW = 25;
   localparam int unsigned DW = 16;
   localparam int unsigned FW = 20;
   localparam int unsigned PD = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_address = '0;
   logic          busy, done, mem_wr, mem_data_in_ready, pixel_valid, overflow;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_out, pixel_data;
   logic          mem_fifo_full = 1'b0;
   logic [DW-1:0] mem_data_in = '0;
   logic          mem_data_ready = 1'b0;
   logic          pixel_ready = 1'b0;

   always #5 clk = ~clk;

   frame_reader #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH(DW),
      .FRAME_WORDS(FW),
      .PREFETCH_DEPTH(PD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .base_address(base_address),
      .busy(busy),
      .done(done),
      .mem_address(mem_address),
      .mem_wr(mem_wr),
      .mem_data_out(mem_data_out),
      .mem_data_in_ready(mem_data_in_ready),
      .mem_fifo_full(mem_fifo_full),
      .mem_data_in(mem_data_in),
      .mem_data_ready(mem_data_ready),
      .pixel_data(pixel_data),
      .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready),
      .overflow(overflow)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned acc_total = 0;
   int unsigned pix_total = 0;
   int unsigned done_total = 0;

   logic [AW-1:0] exp_addr_q [$];
   logic [DW-1:0] exp_pix_q [$];

   function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
      logic [DW-1:0] w;
      w = a[DW-1:0];
      return w ^ 16'hC35A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Arbiter model: fixed 3-cycle read latency, data derived from the accepted address.
   logic [DW:0]   pipe [3];
   logic          arb_acc;
   logic [AW-1:0] arb_addr;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) pipe[i] = '0;
         mem_data_ready = 1'b0;
         mem_data_in    = '0;
      end else begin
         arb_acc  = mem_data_in_ready && !mem_fifo_full;
         arb_addr = mem_address;
         #1;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = {arb_acc, word_of(arb_addr)};
         mem_data_ready = pipe[2][DW];
         mem_data_in    = pipe[2][DW-1:0];
      end
   end

   // Monitor: judges the handshakes that will complete at the next rising edge.
   logic [AW-1:0] mon_ea;
   logic [DW-1:0] mon_ep;
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_data_in_ready && !mem_fifo_full) begin
            acc_total++;
            if (exp_addr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL req_addr: got request 0x%0h expected none", mem_address);
            end else begin
               mon_ea = exp_addr_q.pop_front();
               check("req_addr", 32'(mem_address), 32'(mon_ea));
            end
         end
         if (pixel_valid && pixel_ready) begin
            pix_total++;
            if (exp_pix_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL pixel: got 0x%0h expected none", pixel_data);
            end else begin
               mon_ep = exp_pix_q.pop_front();
               check("pixel", 32'(pixel_data), 32'(mon_ep));
            end
         end
         if (done) done_total++;
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_strobe"}, 32'(mem_data_in_ready), 0);
      check({tag, "_wr"}, 32'(mem_wr), 0);
      check({tag, "_pvalid"}, 32'(pixel_valid), 0);
      check({tag, "_overflow"}, 32'(overflow), 0);
      check({tag, "_addr"}, 32'(mem_address), 0);
      check({tag, "_wdata"}, 32'(mem_data_out), 0);
      check({tag, "_pdata"}, 32'(pixel_data), 0);
   endtask

   task automatic push_frame(input logic [AW-1:0] b);
      for (int i = 0; i < int'(FW); i++) begin
         logic [AW-1:0] a;
         a = b + AW'(i);
         exp_addr_q.push_back(a);
         exp_pix_q.push_back(word_of(a));
      end
   endtask

   task automatic start_frame(input logic [AW-1:0] b);
      push_frame(b);
      @(posedge clk); #1;
      base_address = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 1);
      check("strobe_not_yet", 32'(mem_data_in_ready), 0);
      @(posedge clk); #1;
      check("first_strobe", 32'(mem_data_in_ready), 1);
      check("first_addr", 32'(mem_address), 32'(b));
   endtask

   task automatic wait_frame_done(input string tag);
      int unsigned d0;
      int unsigned n;
      d0 = done_total;
      n = 0;
      while (done_total == d0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1;
      check({tag, "_done_seen"}, done_total - d0, 1);
      check({tag, "_busy_low"}, 32'(busy), 0);
      check({tag, "_done_low"}, 32'(done), 0);
      check({tag, "_addr_left"}, exp_addr_q.size(), 0);
      check({tag, "_pix_left"}, exp_pix_q.size(), 0);
      check({tag, "_overflow"}, 32'(overflow), 0);
      repeat (5) @(posedge clk);
      #1;
      check({tag, "_single_done"}, done_total - d0, 1);
   endtask

   initial begin
      int unsigned a0;
      int unsigned p0;
      int unsigned k;
      int unsigned n;
      logic [AW-1:0] held;

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // Basic frame
      pixel_ready = 1'b1;
      start_frame(25'h100);
      wait_frame_done("basic");

      // Pixel back-pressure: credit limits requests to the buffer depth
      pixel_ready = 1'b0;
      a0 = acc_total;
      start_frame(25'h2000);
      repeat (40) @(posedge clk);
      #1;
      check("bp_accepted", acc_total - a0, PD);
      check("bp_strobe_idle", 32'(mem_data_in_ready), 0);
      check("bp_pvalid", 32'(pixel_valid), 1);
      check("bp_head", 32'(pixel_data), 32'(word_of(25'h2000)));
      pixel_ready = 1'b1;
      wait_frame_done("bp");

      // Arbiter FIFO full: request holds, then exactly one acceptance on release
      a0 = acc_total;
      start_frame(25'h3000);
      repeat (3) @(posedge clk);
      #1;
      mem_fifo_full = 1'b1;
      k = acc_total - a0;
      check("full_pre_accepts", k, 3);
      held = mem_address;
      check("full_addr", 32'(held), 32'(25'h3003));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("full_hold_addr", 32'(mem_address), 32'(25'h3003));
         check("full_hold_strobe", 32'(mem_data_in_ready), 1);
      end
      mem_fifo_full = 1'b0;
      @(posedge clk); #1;
      check("full_release_one", acc_total - a0, 4);
      check("full_next_addr", 32'(mem_address), 32'(25'h3004));
      wait_frame_done("full");

      // Address wrap at the top of the address space
      start_frame(25'h1FFFFFE);
      wait_frame_done("wrap");

      // Reset mid-frame after 5 pixels, then a full frame again
      p0 = pix_total;
      start_frame(25'h4000);
      n = 0;
      while (pix_total - p0 < 5 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("rst_pixels_before", pix_total - p0, 5);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("midrst");
      exp_addr_q.delete();
      exp_pix_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      start_frame(25'h4000);
      wait_frame_done("after_rst");

      // Start while busy is ignored
      start_frame(25'h5000);
      repeat (4) @(posedge clk);
      #1;
      base_address = 25'h6000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("ign_busy", 32'(busy), 1);
      wait_frame_done("ignore");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
